// File: rtl/wallace_mul_pkg.sv
// Shared sizing helpers for the pipelined Wallace multiplier.
// Optional signed support is enabled by WALLACE_MUL_SIGNED_EN.
package wallace_mul_pkg;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    function automatic int cla_groups(input int n);
        return (n + 3) / 4;
    endfunction

    function automatic int num_cla_grp(input int w);
        return cla_groups(2 * w);
    endfunction

    // One Wallace layer: every group of three rows becomes two.
    function automatic int wal_next(input int r);
        return 2 * (r / 3) + (r % 3);
    endfunction

    function automatic int wal_rows(input int r0, input int s);
        int r;
        r = r0;
        for (int i = 0; i < s; i++) begin
            r = wal_next(r);
        end
        return r;
    endfunction

    function automatic int wal_stages(input int r0);
        int r;
        int n;
        r = r0;
        n = 0;
        while (r > 2) begin
            r = wal_next(r);
            n++;
        end
        return n;
    endfunction

    function automatic int wal_off(input int r0, input int s);
        int o;
        o = 0;
        for (int i = 0; i < s; i++) begin
            o += wal_rows(r0, i);
        end
        return o;
    endfunction

    function automatic logic [63:0] bw_const(input int w);
        logic [63:0] c;
        c = '0;
        c[w] = 1'b1;
        c[2*w-1] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/wallace_pipelined_multiplier_cells.sv
// Single-bit adder cells shared by the Wallace reduction layers.
// Plain combinational full adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/wallace_pipelined_multiplier_cla.sv
// N-bit carry-lookahead adder: 4-bit lookahead groups,
// group carries rippled between groups, no carry-in/out.
module cla_adder_n
    import wallace_mul_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);

    localparam int NG = cla_groups(N);

    logic [NG-1:0] gcin;

    assign gcin[0] = 1'b0;

    for (genvar g = 0; g < NG; g++) begin : grp
        localparam int LO = 4 * g;
        localparam int GW = (N - LO < 4) ? (N - LO) : 4;

        logic [GW-1:0] gg;
        logic [GW-1:0] pg;
        logic [GW-1:0] cc;
        logic [GW-1:0] gl;

        assign gg = a[LO+:GW] & b[LO+:GW];
        assign pg = a[LO+:GW] ^ b[LO+:GW];
        assign gl = {gg[GW-2:0], gcin[g]};

        // Bit k carry: any lower generate propagated through to k.
        always_comb begin
            logic t;
            cc = '0;
            t  = 1'b0;
            for (int k = 0; k < GW; k++) begin
                for (int j = 0; j <= k; j++) begin
                    t = gl[j];
                    for (int m = j; m < k; m++) begin
                        t = t & pg[m];
                    end
                    cc[k] = cc[k] | t;
                end
            end
        end

        assign sum[LO+:GW] = pg ^ cc;

        if (g < NG - 1) begin : gco
            logic gen;
            logic prp;

            always_comb begin
                logic t;
                gen = 1'b0;
                t   = 1'b0;
                for (int j = 0; j < GW; j++) begin
                    t = gg[j];
                    for (int m = j + 1; m < GW; m++) begin
                        t = t & pg[m];
                    end
                    gen = gen | t;
                end
            end

            assign prp = &pg;
            assign gcin[g+1] = gen | (prp & gcin[g]);
        end
    end

endmodule

// File: rtl/wallace_pipelined_multiplier.sv
// Three-stage WIDTHxWIDTH Wallace multiplier with valid/ready and tag.
// Define WALLACE_MUL_SIGNED_EN to add in_signed (Baugh-Wooley).
module wallace_pipelined_multiplier
    import wallace_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef WALLACE_MUL_SIGNED_EN
    input  logic               in_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int PW = prod_w(WIDTH);
`ifdef WALLACE_MUL_SIGNED_EN
    localparam int R0 = WIDTH + 1;
`else
    localparam int R0 = WIDTH;
`endif
    localparam int NST = wal_stages(R0);
    localparam int FO  = wal_off(R0, NST);
    localparam int TOT = FO + 2;
    localparam logic [63:0] BWC = bw_const(WIDTH);

    logic advance;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    logic             v1;
    logic [TAG_W-1:0] t1;
    logic [WIDTH-1:0] pp1  [WIDTH];
    logic [WIDTH-1:0] pp_n [WIDTH];

`ifdef WALLACE_MUL_SIGNED_EN
    logic sg1;

    // Baugh-Wooley: terms with exactly one MSB operand are inverted.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp_n[i][j] = (in_a[j] & in_b[i])
                           ^ (in_signed
                              & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp_n[i][j] = in_a[j] & in_b[i];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            t1  <= '0;
            pp1 <= '{default: '0};
`ifdef WALLACE_MUL_SIGNED_EN
            sg1 <= 1'b0;
`endif
        end else if (advance) begin
            v1  <= in_valid;
            t1  <= in_tag;
            pp1 <= pp_n;
`ifdef WALLACE_MUL_SIGNED_EN
            sg1 <= in_signed;
`endif
        end
    end

    logic [PW-1:0] tr [TOT];

    for (genvar i = 0; i < WIDTH; i++) begin : row0
        assign tr[i] = PW'(pp1[i]) << i;
    end

`ifdef WALLACE_MUL_SIGNED_EN
    assign tr[WIDTH] = sg1 ? BWC[PW-1:0] : '0;
`endif

    for (genvar s = 0; s < NST; s++) begin : lvl
        localparam int R  = wal_rows(R0, s);
        localparam int IO = wal_off(R0, s);
        localparam int OO = wal_off(R0, s + 1);
        localparam int NG = R / 3;

        for (genvar q = 0; q < NG; q++) begin : csa
            logic [PW-1:0] x;
            logic [PW-1:0] y;
            logic [PW-1:0] z;
            logic [PW-1:0] sm;
            logic [PW-2:0] cy;

            assign x = tr[IO+3*q];
            assign y = tr[IO+3*q+1];
            assign z = tr[IO+3*q+2];

            for (genvar c = 0; c < PW - 1; c++) begin : col
                full_adder u_fa (
                    .a  (x[c]),
                    .b  (y[c]),
                    .ci (z[c]),
                    .s  (sm[c]),
                    .co (cy[c])
                );
            end

            // Carry out of the top column falls beyond the product.
            assign sm[PW-1] = x[PW-1] ^ y[PW-1] ^ z[PW-1];

            assign tr[OO+2*q]   = sm;
            assign tr[OO+2*q+1] = {cy, 1'b0};
        end

        for (genvar k = 0; k < R % 3; k++) begin : pass
            assign tr[OO+2*NG+k] = tr[IO+3*NG+k];
        end
    end

    logic             v2;
    logic [TAG_W-1:0] t2;
    logic [PW-1:0]    r2s;
    logic [PW-1:0]    r2c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            t2  <= '0;
            r2s <= '0;
            r2c <= '0;
        end else if (advance) begin
            v2  <= v1;
            t2  <= t1;
            r2s <= tr[FO];
            r2c <= tr[FO+1];
        end
    end

    logic [PW-1:0] sum3;

    cla_adder_n #(
        .N (PW)
    ) u_cla (
        .a   (r2s),
        .b   (r2c),
        .sum (sum3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_product <= '0;
            out_tag     <= '0;
        end else if (advance) begin
            out_valid   <= v2;
            out_product <= sum3;
            out_tag     <= t2;
        end
    end

endmodule

// File: tb/tb_wallace_pipelined_multiplier.sv
// Self-checking bench for wallace_pipelined_multiplier (WIDTH=8).
// Signed scenarios are built when WALLACE_MUL_SIGNED_EN is defined.
module tb_wallace_pipelined_multiplier;

    localparam int WIDTH = 8;
    localparam int TAG_W = 4;
    localparam int PW    = 2 * WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_signed = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [PW-1:0]    out_product;
    logic [TAG_W-1:0] out_tag;

    int tests = 0;
    int fails = 0;

    logic             acc;
    logic             ofire;
    logic             s_ov;
    logic             s_ir;
    logic [PW-1:0]    s_p;
    logic [TAG_W-1:0] s_t;

    logic [PW-1:0]    exp_p [$];
    logic [TAG_W-1:0] exp_t [$];

    always #5 clk = ~clk;

    wallace_pipelined_multiplier #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
`ifdef WALLACE_MUL_SIGNED_EN
        .in_signed   (in_signed),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_tag     (out_tag)
    );

    function automatic logic [PW-1:0] ref_mul(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic sg
    );
        longint x;
        longint y;
        if (sg) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        return PW'(x * y);
    endfunction

    task automatic tick(
        input logic v,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [TAG_W-1:0] t,
        input logic sg,
        input logic ordy
    );
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_tag    = t;
        in_signed = sg;
        out_ready = ordy;
        #1;
        s_ir  = in_ready;
        s_ov  = out_valid;
        s_p   = out_product;
        s_t   = out_tag;
        acc   = v && in_ready;
        ofire = out_valid && ordy;
        if (acc) begin
            exp_p.push_back(ref_mul(a, b, sg));
            exp_t.push_back(t);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_product !== '0 || out_tag !== '0) begin
            fails++;
            $display("FAIL reset_state got v=%b p=%h t=%h want 0/0/0",
                     out_valid, out_product, out_tag);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [PW-1:0] ep;
        logic [TAG_W-1:0] et;
        tick(1'b1, 8'hFF, 8'hFF, 4'h5, 1'b0, 1'b1);
        tests++;
        if (acc !== 1'b1) begin
            fails++;
            $display("FAIL single_accept got %b want 1", acc);
        end
        for (int k = 1; k <= 3; k++) begin
            tick(1'b0, '0, '0, '0, 1'b0, 1'b1);
            tests++;
            if (s_ov !== (k == 3)) begin
                fails++;
                $display("FAIL single_latency cyc %0d got v=%b want %b",
                         k, s_ov, (k == 3));
            end
        end
        tests++;
        if (s_p !== 16'hFE01 || s_t !== 4'h5) begin
            fails++;
            $display("FAIL single_max got %h/%h want fe01/5", s_p, s_t);
        end
        if (ofire && exp_p.size() > 0) begin
            ep = exp_p.pop_front();
            et = exp_t.pop_front();
        end
    endtask

    task automatic test_back_to_back();
        int got;
        int first;
        int last;
        logic [PW-1:0] ep;
        logic [TAG_W-1:0] et;
        got = 0;
        first = -1;
        last = -1;
        for (int c = 0; c < 300 && got < 256; c++) begin
            if (c < 256) begin
                tick(1'b1, WIDTH'($urandom), WIDTH'($urandom),
                     TAG_W'($urandom), 1'b0, 1'b1);
                tests++;
                if (acc !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_accept cyc %0d got %b want 1", c, acc);
                end
            end else begin
                tick(1'b0, '0, '0, '0, 1'b0, 1'b1);
            end
            if (ofire) begin
                tests++;
                ep = exp_p.pop_front();
                et = exp_t.pop_front();
                if (s_p !== ep || s_t !== et) begin
                    fails++;
                    $display("FAIL b2b_data #%0d got %h/%h want %h/%h",
                             got, s_p, s_t, ep, et);
                end
                if (first < 0) first = c;
                last = c;
                got++;
            end
        end
        tests++;
        if (got != 256 || first != 3 || last != 258) begin
            fails++;
            $display("FAIL b2b_rate got n=%0d first=%0d last=%0d want 256/3/258",
                     got, first, last);
        end
    endtask

    task automatic test_backpressure();
        int drained;
        logic [PW-1:0] ep;
        logic [TAG_W-1:0] et;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, WIDTH'($urandom), WIDTH'($urandom),
                 TAG_W'(k + 9), 1'b0, 1'b1);
            tests++;
            if (acc !== 1'b1) begin
                fails++;
                $display("FAIL bp_fill %0d got %b want 1", k, acc);
            end
        end
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, WIDTH'($urandom), WIDTH'($urandom), 4'hF, 1'b0, 1'b0);
            tests++;
            if (s_ir !== 1'b0 || acc !== 1'b0) begin
                fails++;
                $display("FAIL bp_in_ready cyc %0d got %b want 0", k, s_ir);
            end
            tests++;
            if (s_ov !== 1'b1 || s_p !== exp_p[0] || s_t !== exp_t[0]) begin
                fails++;
                $display("FAIL bp_hold cyc %0d got %b/%h/%h want 1/%h/%h",
                         k, s_ov, s_p, s_t, exp_p[0], exp_t[0]);
            end
        end
        drained = 0;
        for (int c = 0; c < 8; c++) begin
            tick(1'b0, '0, '0, '0, 1'b0, 1'b1);
            if (ofire) begin
                tests++;
                if (exp_p.size() == 0) begin
                    fails++;
                    $display("FAIL bp_dup got %h/%h want none", s_p, s_t);
                end else begin
                    ep = exp_p.pop_front();
                    et = exp_t.pop_front();
                    if (s_p !== ep || s_t !== et) begin
                        fails++;
                        $display("FAIL bp_drain got %h/%h want %h/%h",
                                 s_p, s_t, ep, et);
                    end
                end
                drained++;
            end
        end
        tests++;
        if (drained != 3 || exp_p.size() != 0) begin
            fails++;
            $display("FAIL bp_count got %0d want 3", drained);
        end
    endtask

    task automatic test_random_stall();
        logic [PW-1:0] ep;
        logic [TAG_W-1:0] et;
        for (int c = 0; c < 400; c++) begin
            tick((c < 300) && ($urandom_range(0, 3) != 0),
                 WIDTH'($urandom), WIDTH'($urandom), TAG_W'($urandom),
                 1'b0, (c >= 300) || ($urandom_range(0, 2) != 0));
            if (ofire) begin
                tests++;
                if (exp_p.size() == 0) begin
                    fails++;
                    $display("FAIL rnd_extra got %h want none", s_p);
                end else begin
                    ep = exp_p.pop_front();
                    et = exp_t.pop_front();
                    if (s_p !== ep || s_t !== et) begin
                        fails++;
                        $display("FAIL rnd_data got %h/%h want %h/%h",
                                 s_p, s_t, ep, et);
                    end
                end
            end
        end
        tests++;
        if (exp_p.size() != 0) begin
            fails++;
            $display("FAIL rnd_lost got %0d left want 0", exp_p.size());
        end
    endtask

    task automatic test_zero_identity();
        logic [WIDTH-1:0] av [4];
        logic [WIDTH-1:0] bv [4];
        logic [PW-1:0] want [4];
        logic [PW-1:0] res [$];
        logic [PW-1:0] ep;
        logic [TAG_W-1:0] et;
        av = '{8'h00, 8'h01, 8'hA5, 8'hFF};
        bv = '{8'hA5, 8'hA5, 8'h00, 8'h01};
        want = '{16'h0000, 16'h00A5, 16'h0000, 16'h00FF};
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, av[k], bv[k], TAG_W'(k), 1'b0, 1'b1);
        end
        for (int c = 0; c < 8; c++) begin
            if (ofire) begin
                ep = exp_p.pop_front();
                et = exp_t.pop_front();
                res.push_back(s_p);
            end
            tick(1'b0, '0, '0, '0, 1'b0, 1'b1);
        end
        tests++;
        if (res.size() != 4) begin
            fails++;
            $display("FAIL zi_count got %0d want 4", res.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (res[k] !== want[k]) begin
                    fails++;
                    $display("FAIL zi_%0d got %h want %h", k, res[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [PW-1:0] ep;
        logic [TAG_W-1:0] et;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, WIDTH'($urandom_range(1, 255)),
                 WIDTH'($urandom_range(1, 255)), 4'hA, 1'b0, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL ar_inflight got %b want 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_product !== '0 || out_tag !== '0) begin
            fails++;
            $display("FAIL ar_clear got %b/%h/%h want 0/0/0",
                     out_valid, out_product, out_tag);
        end
        exp_p.delete();
        exp_t.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, '0, '0, '0, 1'b0, 1'b1);
            tests++;
            if (s_ov !== 1'b0) begin
                fails++;
                $display("FAIL ar_stale cyc %0d got %b want 0", c, s_ov);
            end
        end
        tick(1'b1, 8'h12, 8'h34, 4'h3, 1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick(1'b0, '0, '0, '0, 1'b0, 1'b1);
            tests++;
            if (s_ov !== (k == 3)) begin
                fails++;
                $display("FAIL ar_latency cyc %0d got %b want %b",
                         k, s_ov, (k == 3));
            end
        end
        tests++;
        if (s_p !== 16'h03A8 || s_t !== 4'h3) begin
            fails++;
            $display("FAIL ar_result got %h/%h want 03a8/3", s_p, s_t);
        end
        if (ofire && exp_p.size() > 0) begin
            ep = exp_p.pop_front();
            et = exp_t.pop_front();
        end
    endtask

`ifdef WALLACE_MUL_SIGNED_EN
    task automatic test_signed();
        logic [PW-1:0] res [$];
        logic [PW-1:0] want [3];
        logic [PW-1:0] ep;
        logic [TAG_W-1:0] et;
        logic sg;
        want = '{16'h0080, 16'hC080, 16'hFE01};
        tick(1'b1, 8'h80, 8'hFF, 4'h1, 1'b1, 1'b1);
        tick(1'b1, 8'h80, 8'h7F, 4'h2, 1'b1, 1'b1);
        tick(1'b1, 8'hFF, 8'hFF, 4'h3, 1'b0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            if (ofire) begin
                ep = exp_p.pop_front();
                et = exp_t.pop_front();
                res.push_back(s_p);
            end
            tick(1'b0, '0, '0, '0, 1'b0, 1'b1);
        end
        tests++;
        if (res.size() != 3) begin
            fails++;
            $display("FAIL sg_count got %0d want 3", res.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (res[k] !== want[k]) begin
                    fails++;
                    $display("FAIL sg_%0d got %h want %h", k, res[k], want[k]);
                end
            end
        end
        for (int c = 0; c < 80; c++) begin
            sg = 1'($urandom);
            tick(c < 64, WIDTH'($urandom), WIDTH'($urandom),
                 TAG_W'($urandom), sg, 1'b1);
            if (ofire) begin
                tests++;
                ep = exp_p.pop_front();
                et = exp_t.pop_front();
                if (s_p !== ep || s_t !== et) begin
                    fails++;
                    $display("FAIL sg_rnd got %h/%h want %h/%h",
                             s_p, s_t, ep, et);
                end
            end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random_stall();
        test_zero_identity();
        test_async_reset();
`ifdef WALLACE_MUL_SIGNED_EN
        test_signed();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
